// File: rtl/sobel_pkg.sv
// sobel_pkg: shared constants, direction encoding and width helper for the Sobel gradient engine
package sobel_pkg;
    localparam int LAT = 5;
    localparam logic [1:0] MODE_BIT = 2'd0;
    localparam logic [1:0] MODE_MAG = 2'd1;
    localparam logic [1:0] MODE_DIR = 2'd2;
    typedef enum logic [1:0] {DIR_H = 2'd0, DIR_D = 2'd1, DIR_V = 2'd2, DIR_A = 2'd3} dir_e;
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/sobel_line_window.sv
// sobel_line_window: beat counters, two line buffers and the 3x3 window feeding the gradient stages
module sobel_line_window
    import sobel_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        vsync_i,
    input  logic                        href_i,
    input  logic                        clken_i,
    input  logic [DATA_W-1:0]           data_i,
    output logic                        sof_o,
    output logic [2:0][2:0][DATA_W-1:0] win_o,
    output logic                        valid_o
);
    localparam int CW = cnt_w(IMG_HDISP);
    localparam int RW = cnt_w(IMG_VDISP);
    localparam int AW = IMG_HDISP > 1 ? $clog2(IMG_HDISP) : 1;

    logic [DATA_W-1:0] lb1_q [IMG_HDISP];
    logic [DATA_W-1:0] lb2_q [IMG_HDISP];
    logic [CW-1:0] col_q, col_d, col_e;
    logic [RW-1:0] row_q, row_d, row_e;
    logic vs_q, hr_q, ok_q, ok_d, valid_q, valid_d, beat, h_fall, in_line;
    logic [AW-1:0] addr;
    logic [DATA_W-1:0] top, mid;
    logic [2:0][DATA_W-1:0] col_in;
    logic [2:0][2:0][DATA_W-1:0] win_q;

    // a vsync rise clears the counters before the same-cycle beat is placed
    always_comb begin
        sof_o   = vsync_i & ~vs_q;
        h_fall  = hr_q & ~href_i;
        beat    = clken_i & href_i;
        col_e   = sof_o ? '0 : col_q;
        row_e   = sof_o ? '0 : row_q;
        in_line = col_e < CW'(IMG_HDISP);
        addr    = col_e[AW-1:0];
        top     = in_line ? lb2_q[addr] : '0;
        mid     = in_line ? lb1_q[addr] : '0;
        col_in  = {data_i, mid, top};
        col_d   = h_fall ? '0 : (beat && in_line) ? col_e + 1'b1 : col_e;
        row_d   = (h_fall && row_e < RW'(IMG_VDISP)) ? row_e + 1'b1 : row_e;
        ok_d    = ok_q | sof_o;
        valid_d = beat && ok_d && in_line && col_e >= CW'(2) && row_e >= RW'(2) && row_e < RW'(IMG_VDISP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q    <= 1'b1;
            hr_q    <= 1'b0;
            ok_q    <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            win_q   <= '0;
        end else begin
            vs_q    <= vsync_i;
            hr_q    <= href_i;
            ok_q    <= ok_d;
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            if (beat)
                for (int i = 0; i < 3; i++)
                    win_q[i] <= {col_in[i], win_q[i][2:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (beat && in_line) begin
            lb1_q[addr] <= data_i;
            lb2_q[addr] <= mid;
        end
    end

    assign win_o   = win_q;
    assign valid_o = valid_q;
endmodule

// File: rtl/sobel_grad_engine.sv
// sobel_grad_engine: streaming 3x3 Sobel L1 magnitude with edge bit, scaled magnitude or direction output
module sobel_grad_engine
    import sobel_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int MAG_SHIFT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] thresh,
    input  logic [1:0]        mode,
    input  logic              per_img_vsync,
    input  logic              per_img_href,
    input  logic              per_img_clken,
    input  logic [DATA_W-1:0] per_img_data,
    output logic              post_img_vsync,
    output logic              post_img_href,
    output logic              post_img_clken,
    output logic              post_img_bit,
    output logic [DATA_W-1:0] post_img_data,
    output logic [1:0]        post_img_dir
);
    localparam int SW = DATA_W + 2;
    localparam int GW = DATA_W + 3;
    localparam int PW = DATA_W + 5;

    logic [2:0][2:0][DATA_W-1:0] w;
    logic v1, sof;
    logic [1:0] mode_q, dir4_d, dir4_q, dir_d, dir_q;
    logic [DATA_W-1:0] thr_q, data_d, data_q, sat;
    logic [SW-1:0] gxp_q, gxn_q, gyp_q, gyn_q, ax_d, ay_d, ax_q, ay_q;
    logic [GW-1:0] gx, gy, mag_d, mag_q, shifted;
    logic [PW-1:0] ax2, ay2, ax5, ay5;
    logic v2_q, v3_q, v4_q, sx_q, sy_q, edge_d, bit_d, bit_q;
    logic [LAT-1:0][2:0] dly_q;

    sobel_line_window #(.DATA_W(DATA_W), .IMG_HDISP(IMG_HDISP), .IMG_VDISP(IMG_VDISP)) u_win (
        .clk(clk), .rst(rst), .vsync_i(per_img_vsync), .href_i(per_img_href),
        .clken_i(per_img_clken), .data_i(per_img_data), .sof_o(sof), .win_o(w), .valid_o(v1)
    );

    function automatic logic [SW-1:0] ksum(input logic [DATA_W-1:0] a, b, c);
        return SW'(a) + (SW'(b) << 1) + SW'(c);
    endfunction

    always_comb begin
        gx      = GW'(gxp_q) - GW'(gxn_q);
        gy      = GW'(gyp_q) - GW'(gyn_q);
        ax_d    = SW'(gx[GW-1] ? -gx : gx);
        ay_d    = SW'(gy[GW-1] ? -gy : gy);
        mag_d   = GW'(ax_q) + GW'(ay_q);
        ax2     = PW'(ax_q) << 1;
        ay2     = PW'(ay_q) << 1;
        ax5     = PW'(ax_q) * PW'(5);
        ay5     = PW'(ay_q) * PW'(5);
        dir4_d  = ay5 < ax2 ? DIR_H : ax5 < ay2 ? DIR_V : sx_q == sy_q ? DIR_D : DIR_A;
        shifted = mag_q >> MAG_SHIFT;
        sat     = |shifted[GW-1:DATA_W] ? '1 : shifted[DATA_W-1:0];
        edge_d  = v4_q && mag_q > GW'(thr_q);
        bit_d   = edge_d && mode_q == MODE_BIT;
        dir_d   = v4_q ? dir4_q : 2'd0;
        data_d  = !v4_q ? '0 : mode_q == MODE_BIT ? {DATA_W{edge_d}} : mode_q == MODE_MAG ? sat :
                  mode_q == MODE_DIR ? DATA_W'(dir4_q) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= '0;
            thr_q  <= '0;
            {v2_q, v3_q, v4_q, sx_q, sy_q, bit_q} <= '0;
            {gxp_q, gxn_q, gyp_q, gyn_q, ax_q, ay_q} <= '0;
            mag_q  <= '0;
            dir4_q <= '0;
            dir_q  <= '0;
            data_q <= '0;
            dly_q  <= '0;
        end else begin
            if (sof) begin
                mode_q <= mode;
                thr_q  <= thresh;
            end
            v2_q   <= v1;
            gxp_q  <= ksum(w[0][2], w[1][2], w[2][2]);
            gxn_q  <= ksum(w[0][0], w[1][0], w[2][0]);
            gyp_q  <= ksum(w[2][0], w[2][1], w[2][2]);
            gyn_q  <= ksum(w[0][0], w[0][1], w[0][2]);
            v3_q   <= v2_q;
            ax_q   <= ax_d;
            ay_q   <= ay_d;
            sx_q   <= gx[GW-1];
            sy_q   <= gy[GW-1];
            v4_q   <= v3_q;
            mag_q  <= mag_d;
            dir4_q <= dir4_d;
            bit_q  <= bit_d;
            data_q <= data_d;
            dir_q  <= dir_d;
            dly_q  <= {dly_q[LAT-2:0], {per_img_vsync, per_img_href, per_img_clken}};
        end
    end

    assign {post_img_vsync, post_img_href, post_img_clken} = dly_q[LAT-1];
    assign post_img_bit  = bit_q;
    assign post_img_data = data_q;
    assign post_img_dir  = dir_q;
endmodule

// File: tb/tb_sobel_grad_engine.sv
// tb_sobel_grad_engine: scoreboard bench for sobel_grad_engine on a small 8x6 frame
module tb_sobel_grad_engine;
    localparam int H = 8;
    localparam int V = 6;

    logic clk = 0, rst = 1, vsync = 0, href = 0, clken = 0;
    logic [7:0] thresh = 0, data = 0, pdata;
    logic [1:0] mode = 0, pdir;
    logic pvs, phr, pck, pbit, en = 0;

    sobel_grad_engine #(.DATA_W(8), .IMG_HDISP(H), .IMG_VDISP(V), .MAG_SHIFT(2)) dut (
        .clk(clk), .rst(rst), .thresh(thresh), .mode(mode),
        .per_img_vsync(vsync), .per_img_href(href), .per_img_clken(clken), .per_img_data(data),
        .post_img_vsync(pvs), .post_img_href(phr), .post_img_clken(pck),
        .post_img_bit(pbit), .post_img_data(pdata), .post_img_dir(pdir)
    );

    always #5 clk = ~clk;

    int img [V][H];
    int fok = 0, fmode = 0, fthr = 0;
    int nvec = 0, nerr = 0, nbit = 0, n255 = 0;
    logic [10:0] q [$];
    logic [2:0] h [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] ref_out(input int r, input int c);
        int p [3][3];
        int gx, gy, ax, ay, mag, d, dat;
        logic b;
        if (fok == 0 || r < 2 || c < 2 || c >= H || r >= V) return '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p[i][j] = img[r-2+i][c-2+j];
        gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
        gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
        ax = gx < 0 ? -gx : gx;
        ay = gy < 0 ? -gy : gy;
        mag = ax + ay;
        d = (5*ay < 2*ax) ? 0 : (5*ax < 2*ay) ? 2 : ((gx < 0) == (gy < 0)) ? 1 : 3;
        b = mag > fthr;
        dat = fmode == 0 ? (b ? 255 : 0) : fmode == 1 ? ((mag >> 2) > 255 ? 255 : (mag >> 2)) :
              fmode == 2 ? d : 0;
        return {fmode == 0 && b, dat[7:0], d[1:0]};
    endfunction

    task automatic fill(input int kind);
        for (int r = 0; r < V; r++)
            for (int c = 0; c < H; c++)
                img[r][c] = kind == 0 ? 100 : kind == 1 ? (c < 4 ? 0 : 255) : (c > r ? 255 : 0);
    endtask

    task automatic frame(input int kind, input int md, input int th, input int longrow,
                         input int rstrow, input int mdrow, input int newmd, input bit gaps);
        int n, c, k;
        fill(kind);
        mode = md[1:0];
        thresh = th[7:0];
        vsync = 1;
        fok = 1;
        fmode = md;
        fthr = th;
        repeat (3) tick();
        for (int r = 0; r < V; r++) begin
            if (r == rstrow) begin
                mode = newmd[1:0];
                rst = 1;
                tick();
                rst = 0;
                fok = 0;
            end
            if (r == mdrow) mode = newmd[1:0];
            n = r == longrow ? H + 3 : H;
            c = 0;
            k = 0;
            while (c < n) begin
                href = 1;
                clken = !(gaps && k % 3 == 2);
                data = c < H ? 8'(img[r][c]) : 8'hA5;
                if (clken) begin
                    q.push_back(ref_out(r, c));
                    c++;
                end
                k++;
                tick();
            end
            href = 0;
            clken = 0;
            repeat (8) tick();
        end
        vsync = 0;
        repeat (6) tick();
    endtask

    task automatic check_cnt(input string name, input int got, input int want);
        nvec++;
        if (got != want) begin
            nerr++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (en) begin
            nvec++;
            if ({pvs, phr, pck} !== h[4]) begin
                nerr++;
                $display("FAIL sync_delay: got %b want %b", {pvs, phr, pck}, h[4]);
            end
            if (phr && pck) begin
                nvec++;
                if (q.size() == 0) begin
                    nerr++;
                    $display("FAIL pix_unexpected: got %h want none", {pbit, pdata, pdir});
                end else begin
                    logic [10:0] e;
                    e = q.pop_front();
                    if ({pbit, pdata, pdir} !== e) begin
                        nerr++;
                        $display("FAIL pix: got bit=%b data=%0d dir=%0d want bit=%b data=%0d dir=%0d",
                                 pbit, pdata, pdir, e[10], e[9:2], e[1:0]);
                    end
                end
                if (pbit) nbit++;
                if (pdata == 8'd255) n255++;
            end
        end
        if (rst) for (int i = 0; i < 5; i++) h[i] = '0;
        else begin
            for (int i = 4; i > 0; i--) h[i] = h[i-1];
            h[0] = {vsync, href, clken};
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) tick();
        rst = 0;
        en = 1;
        @(negedge clk);
        check_cnt("reset_outputs", int'({pbit, pdata, pdir}), 0);
        repeat (4) tick();
        nbit = 0;
        frame(0, 0, 0, -1, -1, -1, 0, 0);
        check_cnt("flat_edges", nbit, 0);
        nbit = 0;
        frame(1, 0, 100, -1, -1, -1, 0, 0);
        check_cnt("step_edges", nbit, 8);
        n255 = 0;
        frame(1, 1, 100, -1, -1, 3, 2, 0);
        check_cnt("step_mag255", n255, 8);
        frame(1, 2, 100, -1, -1, -1, 0, 0);
        frame(2, 2, 100, -1, -1, -1, 0, 1);
        frame(1, 1, 100, 2, -1, -1, 0, 0);
        nbit = 0;
        frame(1, 0, 100, -1, 3, -1, 1, 0);
        check_cnt("rst_edges", nbit, 2);
        n255 = 0;
        frame(1, 1, 100, -1, -1, -1, 0, 1);
        check_cnt("post_rst_mag255", n255, 8);
        frame(1, 3, 50, -1, -1, -1, 0, 0);
        repeat (10) tick();
        check_cnt("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
